// File: rtl/serial_adder_unit.sv
// serial_adder_unit: bit-serial WIDTH-bit adder (and optional subtractor).
// One fullAdder is reused across WIDTH cycles, LSB first, with the carry
// held in a flop between bits. Results and NZCV flags go out on a
// valid/ready handshake.
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds the 'sub' port; A - B).

module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cIn,
  output logic s,
  output logic cOut
);
  assign s    = a ^ b ^ cIn;
  assign cOut = (a & b) | (cIn & (a ^ b));
endmodule

module serial_adder_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  // Counter is one bit wider than needed so it can never wrap mid-op.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_flag_c;
  logic             r_flag_v;

  logic w_sum;
  logic w_cout;
  logic w_sub;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif

  fullAdder u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cIn  (r_carry),
    .s    (w_sum),
    .cOut (w_cout)
  );

  // Control FSM plus serial datapath. The shift register r_sum_sh collects
  // bits during RUN; r_result is only updated on the final bit so the
  // visible result stays stable between completions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_sum_sh    <= '0;
      r_result    <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_flag_c    <= 1'b0;
      r_flag_v    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh     <= a;
            r_b_sh     <= w_sub ? ~b : b;
            r_carry    <= w_sub;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_sum_sh <= {w_sum, r_sum_sh[WIDTH-1:1]};
          r_carry  <= w_cout;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_result    <= {w_sum, r_sum_sh[WIDTH-1:1]};
            r_flag_c    <= w_cout;
            r_flag_v    <= r_carry ^ w_cout;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flag_c    = r_flag_c;
  assign flag_v    = r_flag_v;
  assign flag_n    = r_result[WIDTH-1];
  assign flag_z    = (r_result == '0);

endmodule

// File: tb/tb_serial_adder_unit.sv
// Bench for serial_adder_unit: directed WIDTH=8 scenarios and a WIDTH=64
// random regression against an arithmetic reference model.
module tb_serial_adder_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       iv8, ir8, ov8, or8, s8, n8, z8, c8, v8;
  logic [7:0] a8, b8, r8;
  // WIDTH=64 instance
  logic        iv64, ir64, ov64, or64, s64, n64, z64, c64, v64;
  logic [63:0] a64, b64, r64;

  serial_adder_unit #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(s8),
`endif
    .out_valid(ov8), .out_ready(or8), .result(r8),
    .flag_n(n8), .flag_z(z8), .flag_c(c8), .flag_v(v8)
  );

  serial_adder_unit #(.WIDTH(64)) u64 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv64), .in_ready(ir64),
    .a(a64), .b(b64),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(s64),
`endif
    .out_valid(ov64), .out_ready(or64), .result(r64),
    .flag_n(n64), .flag_z(z64), .flag_c(c64), .flag_v(v64)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [67:0] o, input logic [67:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Reference: plain w-bit arithmetic, flags from operand/result signs.
  function automatic logic [67:0] model(input int w, input logic [63:0] x,
                                        input logic [63:0] y, input logic s);
    logic [63:0] m, r;
    logic [64:0] t;
    logic sa, sb, sr, c, v;
    m = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    x = x & m;
    y = y & m;
    sa = x[w-1];
    sb = y[w-1];
    if (s) begin
      r = (x - y) & m;
      c = (x >= y);
      sr = r[w-1];
      v = (sa != sb) && (sr != sa);
    end else begin
      t = {1'b0, x} + {1'b0, y};
      r = t[63:0] & m;
      c = t[w];
      sr = r[w-1];
      v = (sa == sb) && (sr != sa);
    end
    return {r, sr, (r == 64'd0), c, v};
  endfunction

  function automatic logic [67:0] obs8();
    return {56'h0, r8, n8, z8, c8, v8};
  endfunction

  function automatic logic [67:0] obs64();
    return {r64, n64, z64, c64, v64};
  endfunction

  function automatic logic [63:0] pick64();
    case ($urandom_range(7))
      0: return 64'h0;
      1: return {64{1'b1}};
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issue one WIDTH=8 op and wait for out_valid; lat counts edges after accept.
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic s,
                     output int lat);
    @(negedge clk);
    a8 = x; b8 = y; s8 = s; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); s8 = ~s;
    lat = 0;
    while (!ov8 && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic hs8();
    or8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or8 = 1'b0;
  endtask

  initial begin
    int lat;
    logic [67:0] held;
    logic [67:0] q[$];
    logic [67:0] exp_v;
    int acc[8];
    int na;
    int done_ops, issued, cyc, nbad;
    logic prev_ov, prev_hs;

    iv8 = 0; or8 = 0; a8 = 0; b8 = 0; s8 = 0;
    iv64 = 0; or64 = 0; a64 = 0; b64 = 0; s64 = 0;

    // Reset values
    #12;
    chk("rst_in_ready8", 68'(ir8), 68'(1'b1));
    chk("rst_out_valid8", 68'(ov8), 68'(1'b0));
    chk("rst_res_flags8", obs8(), {56'h0, 8'h00, 4'b0100});
    chk("rst_res_flags64", obs64(), {64'h0, 4'b0100});
    chk("rst_rdy_vld64", 68'({ir64, ov64}), 68'(2'b10));
    @(negedge clk);
    reset_n = 1'b1;

    // Add with carry wrap
    op8(8'hFF, 8'h01, 1'b0, lat);
    chk("wrap_lat", 68'(lat), 68'(8));
    chk("wrap_res", obs8(), {56'h0, 8'h00, 4'b0110});
    chk("wrap_model", obs8(), model(8, 64'hFF, 64'h01, 1'b0));
    hs8();

    // Add with signed overflow, then backpressure in DONE
    op8(8'h7F, 8'h01, 1'b0, lat);
    chk("ovf_lat", 68'(lat), 68'(8));
    chk("ovf_res", obs8(), {56'h0, 8'h80, 4'b1001});
    chk("ovf_model", obs8(), model(8, 64'h7F, 64'h01, 1'b0));
    held = obs8();
    for (int i = 0; i < 5; i++) begin
      iv8 = (i == 1);
      a8 = 8'h11; b8 = 8'h22;
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid", 68'(ov8), 68'(1'b1));
      chk("bp_in_ready", 68'(ir8), 68'(1'b0));
      chk("bp_hold", obs8(), held);
    end
    iv8 = 1'b0;
    hs8();
    chk("hs_out_valid", 68'(ov8), 68'(1'b0));
    chk("hs_in_ready", 68'(ir8), 68'(1'b1));
    chk("hs_hold", obs8(), {56'h0, 8'h80, 4'b1001});

`ifdef SERIAL_ADDER_SUB_EN
    op8(8'h05, 8'h05, 1'b1, lat);
    chk("sub_eq_res", obs8(), {56'h0, 8'h00, 4'b0110});
    hs8();
    op8(8'h00, 8'h01, 1'b1, lat);
    chk("sub_borrow_lat", 68'(lat), 68'(8));
    chk("sub_borrow_res", obs8(), {56'h0, 8'hFF, 4'b1000});
    hs8();
`endif

    // Reset asserted on the 4th RUN cycle
    @(negedge clk);
    a8 = 8'hA5; b8 = 8'h3C; s8 = 1'b0; iv8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_in_ready", 68'(ir8), 68'(1'b1));
    chk("midrst_out_valid", 68'(ov8), 68'(1'b0));
    chk("midrst_res_flags", obs8(), {56'h0, 8'h00, 4'b0100});
    @(negedge clk);
    reset_n = 1'b1;
    nbad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ov8) nbad++;
    end
    chk("midrst_no_pulse", 68'(nbad), 68'(0));
    op8(8'h12, 8'h34, 1'b0, lat);
    chk("post_rst_lat", 68'(lat), 68'(8));
    chk("post_rst_res", obs8(), {56'h0, 8'h46, 4'b0000});
    hs8();

    // Throughput with in_valid and out_ready held high
    @(negedge clk);
    a8 = 8'h21; b8 = 8'h43; iv8 = 1'b1; or8 = 1'b1;
    na = 0;
    for (int c = 0; c < 40; c++) begin
      if (ir8 && na < 8) begin
        acc[na] = c;
        na++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("tput_count", 68'(na), 68'(4));
    chk("tput_spacing", 68'(acc[1] - acc[0]), 68'(10));
    iv8 = 1'b0;
    for (int c = 0; c < 20 && !ir8; c++) begin
      @(posedge clk);
      @(negedge clk);
    end
    or8 = 1'b0;
    chk("tput_drain", 68'(ir8), 68'(1'b1));

    // WIDTH=64 random regression with gaps and stalls
    done_ops = 0; issued = 0; cyc = 0;
    prev_ov = 1'b0; prev_hs = 1'b0;
    @(negedge clk);
    while (done_ops < 1000 && cyc < 90000) begin
      if (prev_ov && !prev_hs)
        chk("rnd_vld_hold", 68'(ov64), 68'(1'b1));
      or64 = ($urandom_range(3) != 0);
      if (ov64 && or64) begin
        if (q.size() == 0) begin
          chk("rnd_unexpected_out", 68'(1'b1), 68'(1'b0));
        end else begin
          exp_v = q.pop_front();
          chk("rnd_result", obs64(), exp_v);
        end
        done_ops++;
      end
      prev_ov = ov64;
      prev_hs = ov64 && or64;
      iv64 = (issued < 1000) && ($urandom_range(7) != 0);
      a64 = pick64();
      b64 = pick64();
`ifdef SERIAL_ADDER_SUB_EN
      s64 = 1'($urandom_range(1));
`else
      s64 = 1'b0;
`endif
      if (iv64 && ir64) begin
        q.push_back(model(64, a64, b64, s64));
        issued++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    iv64 = 1'b0;
    or64 = 1'b0;
    chk("rnd_ops_done", 68'(done_ops), 68'(1000));
    chk("rnd_queue_empty", 68'(q.size()), 68'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
